// File: rtl/mse_pkg.sv
// Shared types for the multimode shift engine.
//   op_e    : 3-bit command op codes accepted on cmd_op
//   state_e : engine control state (IDLE accepts commands, BUSY iterates a shift)
package mse_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_SAR  = 3'b100,
        OP_ROL  = 3'b101,
        OP_ROR  = 3'b110,
        OP_CLR  = 3'b111
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/mse_step_unit.sv
// Combinational single-step shifter: applies one shift/rotate of k bits.
// Ports:
//   i_value [WIDTH]  current register value
//   i_op    [3]      operation (only SHL/SHR/SAR/ROL/ROR modify the value)
//   i_fill  [1]      fill bit for SHL/SHR
//   i_k     [AW]     bits to move this step, 1..WIDTH
//   o_value [WIDTH]  value after the step
//   o_bit   [1]      last bit moved out (MSB side for left ops, LSB side for right ops)
module mse_step_unit
    import mse_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] i_value,
    input  op_e              i_op,
    input  logic             i_fill,
    input  logic [AW-1:0]    i_k,
    output logic [WIDTH-1:0] o_value,
    output logic             o_bit
);

    localparam logic [AW-1:0] W_AMT = AW'(WIDTH);

    logic [WIDTH-1:0] w_ones;
    logic [WIDTH-1:0] w_lo_mask;
    logic [WIDTH-1:0] w_hi_mask;
    logic [WIDTH-1:0] w_up;
    logic [WIDTH-1:0] w_dn;
    logic [WIDTH-1:0] w_wrap_l;
    logic [WIDTH-1:0] w_wrap_r;
    logic [WIDTH-1:0] w_rt;
    logic [AW-1:0]    w_kc;
    logic [AW-1:0]    w_km1;

    assign w_ones    = '1;
    assign w_kc      = W_AMT - i_k;
    assign w_km1     = i_k - AW'(1);
    // Low / high k-bit masks; k==WIDTH yields all ones.
    assign w_lo_mask = ~(w_ones << i_k);
    assign w_hi_mask = ~(w_ones >> i_k);
    assign w_up      = i_value << i_k;
    assign w_dn      = i_value >> i_k;
    // w_wrap_l[0] is value[WIDTH-k]: the last bit to leave the MSB.
    assign w_wrap_l  = i_value >> w_kc;
    assign w_wrap_r  = i_value << w_kc;
    // w_rt[0] is value[k-1]: the last bit to leave the LSB.
    assign w_rt      = i_value >> w_km1;

    always_comb begin
        o_value = i_value;
        o_bit   = 1'b0;
        case (i_op)
            OP_SHL: begin
                o_value = w_up | (i_fill ? w_lo_mask : '0);
                o_bit   = w_wrap_l[0];
            end
            OP_SHR: begin
                o_value = w_dn | (i_fill ? w_hi_mask : '0);
                o_bit   = w_rt[0];
            end
            OP_SAR: begin
                o_value = w_dn | (i_value[WIDTH-1] ? w_hi_mask : '0);
                o_bit   = w_rt[0];
            end
            OP_ROL: begin
                o_value = w_up | w_wrap_l;
                o_bit   = w_wrap_l[0];
            end
            OP_ROR: begin
                o_value = w_dn | w_wrap_r;
                o_bit   = w_rt[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multimode_shift_engine.sv
// Command-driven shift/rotate engine. One op per valid/ready handshake;
// multi-bit shifts run iteratively, up to STEP bits per clock.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   flush              synchronous abort of the in-flight op
//   cmd_valid/ready    command handshake; ready == IDLE
//   cmd_op [3]         op code (mse_pkg::op_e)
//   cmd_amt [AW]       shift amount, clamped to WIDTH
//   cmd_data [WIDTH]   LOAD value
//   ser_in             SHL/SHR fill bit, latched at accept
//   par_out [WIDTH]    register contents
//   ser_out_msb/lsb    par_out MSB / LSB
//   shout_bit          last bit shifted/rotated out
//   busy               multi-step op in progress
//   done               one-cycle pulse after the final update of an op
module multimode_shift_engine
    import mse_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int STEP  = 1,
    localparam int AW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [AW-1:0]    cmd_amt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             ser_in,
    output logic [WIDTH-1:0] par_out,
    output logic             ser_out_msb,
    output logic             ser_out_lsb,
    output logic             shout_bit,
    output logic             busy,
    output logic             done
);

    localparam logic [AW-1:0] W_AMT    = AW'(WIDTH);
    localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

    state_e           r_state, w_nxt_state;
    logic [WIDTH-1:0] r_par,   w_nxt_par;
    logic             r_shout, w_nxt_shout;
    logic             r_done,  w_nxt_done;
    logic [AW-1:0]    r_rem,   w_nxt_rem;
    op_e              r_op,    w_nxt_op;
    logic             r_fill,  w_nxt_fill;

    logic             w_accept;
    logic [AW-1:0]    w_amt_clamp;
    logic [AW-1:0]    w_rem_src;
    logic [AW-1:0]    w_k;
    op_e              w_op_src;
    logic             w_fill_src;
    logic [WIDTH-1:0] w_step_value;
    logic             w_step_bit;

    assign w_accept    = cmd_valid && (r_state == IDLE) && !flush;
    assign w_amt_clamp = (cmd_amt > W_AMT) ? W_AMT : cmd_amt;

    // In IDLE the step unit works on the incoming command so the first
    // step lands on the accept edge; in BUSY it works on the latched op.
    assign w_rem_src   = (r_state == IDLE) ? w_amt_clamp : r_rem;
    assign w_k         = (w_rem_src < STEP_AMT) ? w_rem_src : STEP_AMT;
    assign w_op_src    = (r_state == IDLE) ? op_e'(cmd_op) : r_op;
    assign w_fill_src  = (r_state == IDLE) ? ser_in : r_fill;

    mse_step_unit #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_step (
        .i_value (r_par),
        .i_op    (w_op_src),
        .i_fill  (w_fill_src),
        .i_k     (w_k),
        .o_value (w_step_value),
        .o_bit   (w_step_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_par   <= '0;
            r_shout <= 1'b0;
            r_done  <= 1'b0;
            r_rem   <= '0;
            r_op    <= OP_NOP;
            r_fill  <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_par   <= w_nxt_par;
            r_shout <= w_nxt_shout;
            r_done  <= w_nxt_done;
            r_rem   <= w_nxt_rem;
            r_op    <= w_nxt_op;
            r_fill  <= w_nxt_fill;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_par   = r_par;
        w_nxt_shout = r_shout;
        w_nxt_done  = 1'b0;
        w_nxt_rem   = r_rem;
        w_nxt_op    = r_op;
        w_nxt_fill  = r_fill;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nxt_op   = op_e'(cmd_op);
                    w_nxt_fill = ser_in;
                    case (op_e'(cmd_op))
                        OP_NOP: w_nxt_done = 1'b1;
                        OP_LOAD: begin
                            w_nxt_par  = cmd_data;
                            w_nxt_done = 1'b1;
                        end
                        OP_CLR: begin
                            w_nxt_par  = '0;
                            w_nxt_done = 1'b1;
                        end
                        default: begin
                            if (w_amt_clamp == '0) begin
                                w_nxt_done = 1'b1;
                            end else begin
                                w_nxt_par   = w_step_value;
                                w_nxt_shout = w_step_bit;
                                w_nxt_rem   = w_amt_clamp - w_k;
                                if (w_amt_clamp == w_k) begin
                                    w_nxt_done = 1'b1;
                                end else begin
                                    w_nxt_state = BUSY;
                                end
                            end
                        end
                    endcase
                end
            end
            BUSY: begin
                if (flush) begin
                    w_nxt_state = IDLE;
                    w_nxt_rem   = '0;
                end else begin
                    w_nxt_par   = w_step_value;
                    w_nxt_shout = w_step_bit;
                    w_nxt_rem   = r_rem - w_k;
                    if (r_rem == w_k) begin
                        w_nxt_state = IDLE;
                        w_nxt_done  = 1'b1;
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    assign cmd_ready   = (r_state == IDLE);
    assign busy        = (r_state == BUSY);
    assign done        = r_done;
    assign par_out     = r_par;
    assign ser_out_msb = r_par[WIDTH-1];
    assign ser_out_lsb = r_par[0];
    assign shout_bit   = r_shout;

endmodule

// File: tb/tb_multimode_shift_engine.sv
module tb_multimode_shift_engine;

    localparam int WIDTH = 8;
    localparam int STEP  = 2;
    localparam int AW    = $clog2(WIDTH) + 1;

    localparam logic [2:0] NOP  = 3'b000;
    localparam logic [2:0] LOAD = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] SHR  = 3'b011;
    localparam logic [2:0] SAR  = 3'b100;
    localparam logic [2:0] ROL  = 3'b101;
    localparam logic [2:0] ROR  = 3'b110;
    localparam logic [2:0] CLR  = 3'b111;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [AW-1:0]    cmd_amt;
    logic [WIDTH-1:0] cmd_data;
    logic             ser_in;
    logic [WIDTH-1:0] par_out;
    logic             ser_out_msb;
    logic             ser_out_lsb;
    logic             shout_bit;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] par;
        logic             sh;
        string            name;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    multimode_shift_engine #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_amt     (cmd_amt),
        .cmd_data    (cmd_data),
        .ser_in      (ser_in),
        .par_out     (par_out),
        .ser_out_msb (ser_out_msb),
        .ser_out_lsb (ser_out_lsb),
        .shout_bit   (shout_bit),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_par"},   32'(par_out),   32'(e.par));
                check({e.name, "_shout"}, 32'(shout_bit), 32'(e.sh));
                check({e.name, "_msb"},   32'(ser_out_msb), 32'(e.par[WIDTH-1]));
                check({e.name, "_lsb"},   32'(ser_out_lsb), 32'(e.par[0]));
            end
        end
    end

    // Issue one command at a negedge, then wait for its done pulse.
    // edges: expected done latency in cycles after the accept edge.
    // poke: toggle an ignored LOAD request while the engine is busy.
    task automatic run_op(input string name, input logic [2:0] op, input logic [AW-1:0] amt,
                          input logic [WIDTH-1:0] data, input logic fill,
                          input logic [WIDTH-1:0] exp_par, input logic exp_sh,
                          input int edges, input bit poke);
        exp_t e;
        int   cnt;
        int   busy_cnt;
        e.par  = exp_par;
        e.sh   = exp_sh;
        e.name = name;
        exp_q.push_back(e);
        cmd_op    = op;
        cmd_amt   = amt;
        cmd_data  = data;
        ser_in    = fill;
        cmd_valid = 1'b1;
        check({name, "_ready"}, 32'(cmd_ready), 32'(1));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        ser_in = ~fill;
        cnt = 0;
        busy_cnt = 0;
        while (cnt < 50) begin
            @(negedge clk);
            cnt++;
            if (done) break;
            if (busy) busy_cnt++;
            if (poke && busy) begin
                cmd_op    = LOAD;
                cmd_data  = 8'h00;
                cmd_valid = cnt[0];
            end
        end
        cmd_valid = 1'b0;
        check({name, "_latency"}, 32'(cnt), 32'(edges));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(edges - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        cmd_amt   = '0;
        cmd_data  = '0;
        ser_in    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_par",   32'(par_out),   32'(0));
        check("rst_shout", 32'(shout_bit), 32'(0));
        check("rst_done",  32'(done),      32'(0));
        check("rst_ready", 32'(cmd_ready), 32'(1));
        check("rst_busy",  32'(busy),      32'(0));
        rst = 1'b0;
        @(negedge clk);

        run_op("load_a5", LOAD, 4'd0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1, 1'b0);
        run_op("shl3",    SHL,  4'd3, 8'h00, 1'b1, 8'h2F, 1'b1, 2, 1'b0);
        run_op("load_96", LOAD, 4'd0, 8'h96, 1'b0, 8'h96, 1'b1, 1, 1'b0);
        run_op("sar4",    SAR,  4'd4, 8'h00, 1'b1, 8'hF9, 1'b0, 2, 1'b0);
        run_op("load_96b",LOAD, 4'd0, 8'h96, 1'b0, 8'h96, 1'b0, 1, 1'b0);
        run_op("shr4",    SHR,  4'd4, 8'h00, 1'b0, 8'h09, 1'b0, 2, 1'b0);
        run_op("load_3c", LOAD, 4'd0, 8'h3C, 1'b0, 8'h3C, 1'b0, 1, 1'b0);
        run_op("ror12",   ROR,  4'd12, 8'h00, 1'b0, 8'h3C, 1'b0, 4, 1'b1);
        run_op("load_ff", LOAD, 4'd0, 8'hFF, 1'b0, 8'hFF, 1'b0, 1, 1'b0);

        // SHL by 8, flushed in the second BUSY cycle: no done, partial value kept.
        cmd_op    = SHL;
        cmd_amt   = 4'd8;
        ser_in    = 1'b0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("flush_busy1", 32'(busy), 32'(1));
        @(negedge clk);
        check("flush_busy2", 32'(busy), 32'(1));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_par",   32'(par_out),   32'(8'hF0));
        check("flush_ready", 32'(cmd_ready), 32'(1));
        check("flush_done",  32'(done),      32'(0));
        check("flush_shout", 32'(shout_bit), 32'(1));
        @(negedge clk);
        check("flush_done2", 32'(done), 32'(0));

        // Flush in IDLE blocks acceptance of a pending LOAD.
        cmd_op    = LOAD;
        cmd_data  = 8'h11;
        cmd_valid = 1'b1;
        flush     = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        flush     = 1'b0;
        check("idle_flush_par", 32'(par_out), 32'(8'hF0));
        @(negedge clk);
        check("idle_flush_done", 32'(done), 32'(0));

        run_op("load_81", LOAD, 4'd0, 8'h81, 1'b0, 8'h81, 1'b1, 1, 1'b0);

        // Asynchronous reset in the middle of a ROL.
        cmd_op    = ROL;
        cmd_amt   = 4'd5;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("rol_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        #1;
        check("midrst_par",   32'(par_out),   32'(0));
        check("midrst_shout", 32'(shout_bit), 32'(0));
        check("midrst_ready", 32'(cmd_ready), 32'(1));
        check("midrst_busy",  32'(busy),      32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op("load_5a", LOAD, 4'd0, 8'h5A, 1'b0, 8'h5A, 1'b0, 1, 1'b0);
        run_op("rol0",    ROL,  4'd0, 8'h00, 1'b0, 8'h5A, 1'b0, 1, 1'b0);
        run_op("rol3",    ROL,  4'd3, 8'h00, 1'b0, 8'hD2, 1'b0, 2, 1'b0);
        run_op("clr",     CLR,  4'd0, 8'hEE, 1'b0, 8'h00, 1'b0, 1, 1'b0);
        run_op("nop",     NOP,  4'd0, 8'hEE, 1'b0, 8'h00, 1'b0, 1, 1'b0);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
